// File: rtl/updown_mod_counter.sv
// updown_mod_counter: parametrised up/down modulo counter with clear, clamped load,
// wrap or saturate at the bounds, and cascade-ready carry/borrow outputs.
module updown_mod_counter #(
    parameter int SIZE     = 10,
    parameter int MODULUS  = 1024,
    parameter bit SATURATE = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            ld,
    input  logic [SIZE-1:0] ld_val,
    input  logic            inc,
    input  logic            dec,
    output logic [SIZE-1:0] count,
    output logic            co,
    output logic            bo,
    output logic            is_max,
    output logic            is_zero,
    output logic            wrapped
);
    // Top state kept at SIZE+1 bits so MODULUS == 2**SIZE cannot overflow the constant.
    localparam logic [SIZE:0]   MAX_W = (SIZE + 1)'(MODULUS - 1);
    localparam logic [SIZE-1:0] MAX   = MAX_W[SIZE-1:0];
    logic [SIZE-1:0] count_q, count_d;
    logic            wrapped_q, wrapped_d;
    logic            up, down, ovr;
    always_comb begin
        up        = inc & ~dec;
        down      = dec & ~inc;
        ovr       = rst | clr | ld;
        is_max    = {1'b0, count_q} == MAX_W;
        is_zero   = count_q == '0;
        co        = up & is_max & ~ovr;
        bo        = down & is_zero & ~ovr;
        count_d   = count_q;
        wrapped_d = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (ld) begin
            count_d = ({1'b0, ld_val} > MAX_W) ? MAX : ld_val;
        end else if (up) begin
            count_d   = is_max ? (SATURATE ? count_q : '0) : count_q + SIZE'(1);
            wrapped_d = is_max & ~SATURATE;
        end else if (down) begin
            count_d   = is_zero ? (SATURATE ? count_q : MAX) : count_q - SIZE'(1);
            wrapped_d = is_zero & ~SATURATE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            wrapped_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
        end
    end
    assign count   = count_q;
    assign wrapped = wrapped_q;
endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: directed vector table plus hand sequences for the default,
// modulo-10 wrap, modulo-10 saturate and two-stage cascade configurations.
module tb_updown_mod_counter;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int checks = 0;
    int errors = 0;
    logic rst, c_rst;
    // default instance (SIZE=10, MODULUS=1024, wrap)
    logic       d_clr, d_ld, d_inc, d_dec, d_co, d_bo, d_max, d_zero, d_wr;
    logic [9:0] d_ldv, d_cnt;
    // index 0: MODULUS=10 wrap, index 1: MODULUS=10 saturate
    logic [1:0]      t_clr, t_ld, t_inc, t_dec, t_co, t_bo, t_max, t_zero, t_wr;
    logic [1:0][3:0] t_ldv, t_cnt;
    // cascade
    logic       c_inc, lo_co, lo_bo, lo_max, lo_zero, lo_wr, hi_co, hi_bo, hi_max, hi_zero, hi_wr;
    logic [3:0] lo_cnt, hi_cnt;

    updown_mod_counter u_def (.clk(clk), .rst(rst), .clr(d_clr), .ld(d_ld), .ld_val(d_ldv),
        .inc(d_inc), .dec(d_dec), .count(d_cnt), .co(d_co), .bo(d_bo), .is_max(d_max),
        .is_zero(d_zero), .wrapped(d_wr));
    updown_mod_counter #(.SIZE(4), .MODULUS(10), .SATURATE(1'b0)) u_wrap (.clk(clk), .rst(rst),
        .clr(t_clr[0]), .ld(t_ld[0]), .ld_val(t_ldv[0]), .inc(t_inc[0]), .dec(t_dec[0]),
        .count(t_cnt[0]), .co(t_co[0]), .bo(t_bo[0]), .is_max(t_max[0]), .is_zero(t_zero[0]),
        .wrapped(t_wr[0]));
    updown_mod_counter #(.SIZE(4), .MODULUS(10), .SATURATE(1'b1)) u_sat (.clk(clk), .rst(rst),
        .clr(t_clr[1]), .ld(t_ld[1]), .ld_val(t_ldv[1]), .inc(t_inc[1]), .dec(t_dec[1]),
        .count(t_cnt[1]), .co(t_co[1]), .bo(t_bo[1]), .is_max(t_max[1]), .is_zero(t_zero[1]),
        .wrapped(t_wr[1]));
    updown_mod_counter #(.SIZE(4), .MODULUS(10)) u_lo (.clk(clk), .rst(c_rst), .clr(1'b0),
        .ld(1'b0), .ld_val(4'd0), .inc(c_inc), .dec(1'b0), .count(lo_cnt), .co(lo_co),
        .bo(lo_bo), .is_max(lo_max), .is_zero(lo_zero), .wrapped(lo_wr));
    updown_mod_counter #(.SIZE(4), .MODULUS(10)) u_hi (.clk(clk), .rst(c_rst), .clr(1'b0),
        .ld(1'b0), .ld_val(4'd0), .inc(lo_co), .dec(1'b0), .count(hi_cnt), .co(hi_co),
        .bo(hi_bo), .is_max(hi_max), .is_zero(hi_zero), .wrapped(hi_wr));

    typedef struct {
        logic       s, clr, ld;
        logic [3:0] ldv;
        logic       inc, dec, z, m, co, bo;
        logic [3:0] cnt;
        logic       wr;
    } vec_t;
    vec_t vt[22];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // drive one vector: flags and co/bo checked before the edge, count/wrapped after it
    task automatic apply(input int n, input vec_t v);
        t_clr = '0; t_ld = '0; t_inc = '0; t_dec = '0; t_ldv = '0;
        t_clr[v.s] = v.clr; t_ld[v.s] = v.ld; t_ldv[v.s] = v.ldv;
        t_inc[v.s] = v.inc; t_dec[v.s] = v.dec;
        #1;
        chk($sformatf("v%0d is_zero", n), int'(t_zero[v.s]), int'(v.z));
        chk($sformatf("v%0d is_max", n), int'(t_max[v.s]), int'(v.m));
        chk($sformatf("v%0d co", n), int'(t_co[v.s]), int'(v.co));
        chk($sformatf("v%0d bo", n), int'(t_bo[v.s]), int'(v.bo));
        @(posedge clk); #1;
        chk($sformatf("v%0d count", n), int'(t_cnt[v.s]), int'(v.cnt));
        chk($sformatf("v%0d wrapped", n), int'(t_wr[v.s]), int'(v.wr));
    endtask

    initial begin
        //        s clr ld ldv inc dec  z  m co bo cnt wr
        vt[0]  = '{0, 0, 1,  8, 0, 0,  1, 0, 0, 0,  8, 0};
        vt[1]  = '{0, 0, 0,  0, 1, 0,  0, 0, 0, 0,  9, 0};
        vt[2]  = '{0, 0, 0,  0, 1, 0,  0, 1, 1, 0,  0, 1};
        vt[3]  = '{0, 0, 0,  0, 1, 0,  1, 0, 0, 0,  1, 0};
        vt[4]  = '{0, 0, 0,  0, 0, 1,  0, 0, 0, 0,  0, 0};
        vt[5]  = '{0, 0, 0,  0, 0, 1,  1, 0, 0, 1,  9, 1};
        vt[6]  = '{0, 0, 0,  0, 0, 1,  0, 1, 0, 0,  8, 0};
        vt[7]  = '{0, 0, 1,  7, 0, 0,  0, 0, 0, 0,  7, 0};
        vt[8]  = '{0, 0, 1, 15, 0, 0,  0, 0, 0, 0,  9, 0};
        vt[9]  = '{0, 0, 1,  3, 1, 1,  0, 1, 0, 0,  3, 0};
        vt[10] = '{0, 0, 1,  5, 0, 0,  0, 0, 0, 0,  5, 0};
        vt[11] = '{0, 0, 0,  0, 1, 1,  0, 0, 0, 0,  5, 0};
        vt[12] = '{0, 0, 1,  9, 0, 0,  0, 0, 0, 0,  9, 0};
        vt[13] = '{0, 1, 0,  0, 1, 0,  0, 1, 0, 0,  0, 0};
        vt[14] = '{0, 1, 0,  0, 0, 1,  1, 0, 0, 0,  0, 0};
        vt[15] = '{1, 0, 1,  1, 0, 0,  1, 0, 0, 0,  1, 0};
        vt[16] = '{1, 0, 0,  0, 0, 1,  0, 0, 0, 0,  0, 0};
        vt[17] = '{1, 0, 0,  0, 0, 1,  1, 0, 0, 1,  0, 0};
        vt[18] = '{1, 0, 0,  0, 0, 1,  1, 0, 0, 1,  0, 0};
        vt[19] = '{1, 0, 1,  9, 0, 0,  1, 0, 0, 0,  9, 0};
        vt[20] = '{1, 0, 0,  0, 1, 0,  0, 1, 1, 0,  9, 0};
        vt[21] = '{1, 0, 0,  0, 0, 0,  0, 1, 0, 0,  9, 0};
        rst = 1'b1; c_rst = 1'b1; c_inc = 1'b0;
        d_clr = 1'b0; d_ld = 1'b0; d_ldv = '0; d_inc = 1'b0; d_dec = 1'b0;
        t_clr = '0; t_ld = '0; t_ldv = '0; t_inc = '0; t_dec = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; c_rst = 1'b0;
        chk("rst count", int'(d_cnt), 0);
        chk("rst is_zero", int'(d_zero), 1);
        chk("rst wrapped", int'(d_wr), 0);
        chk("rst sat count", int'(t_cnt[1]), 0);
        // default config: 12 up-steps
        d_inc = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (i == 0) chk("def is_zero after step", int'(d_zero), 0);
        end
        d_inc = 1'b0;
        chk("def count 12", int'(d_cnt), 12);
        // full-range modulus: top state is the all-ones value
        d_ld = 1'b1; d_ldv = 10'd1023;
        @(posedge clk); #1;
        d_ld = 1'b0;
        chk("def ld 1023", int'(d_cnt), 1023);
        chk("def is_max", int'(d_max), 1);
        d_inc = 1'b1; #1;
        chk("def co at 1023", int'(d_co), 1);
        @(posedge clk); #1;
        d_inc = 1'b0;
        chk("def wrap up count", int'(d_cnt), 0);
        chk("def wrap up wrapped", int'(d_wr), 1);
        d_dec = 1'b1; #1;
        chk("def bo at 0", int'(d_bo), 1);
        @(posedge clk); #1;
        d_dec = 1'b0;
        chk("def wrap down count", int'(d_cnt), 1023);
        chk("def wrap down wrapped", int'(d_wr), 1);
        @(posedge clk); #1;
        chk("def hold count", int'(d_cnt), 1023);
        chk("def wrapped one cycle", int'(d_wr), 0);
        // modulo-10 wrap / saturate vector table
        foreach (vt[i]) apply(i, vt[i]);
        t_clr = '0; t_ld = '0; t_inc = '0; t_dec = '0;
        // cascade: 100 up-steps return {hi,lo} to 0 with one high-stage carry
        c_inc = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #1;
            chk($sformatf("casc hi_co step %0d", i), int'(hi_co), int'(i == 99));
            @(posedge clk); #1;
        end
        c_inc = 1'b0;
        chk("casc lo after 100", int'(lo_cnt), 0);
        chk("casc hi after 100", int'(hi_cnt), 0);
        c_inc = 1'b1;
        repeat (56) @(posedge clk);
        #1;
        chk("casc lo at 56", int'(lo_cnt), 6);
        chk("casc hi at 56", int'(hi_cnt), 5);
        c_rst = 1'b1; #1;
        chk("casc lo_co under rst", int'(lo_co), 0);
        @(posedge clk); #1;
        c_rst = 1'b0; c_inc = 1'b0;
        chk("casc lo after rst", int'(lo_cnt), 0);
        chk("casc hi after rst", int'(hi_cnt), 0);
        chk("casc lo wrapped after rst", int'(lo_wr), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
Parametrised up/down modulo counter. Generalises the plain increment-only counter with: configurable modulus, down-counting, synchronous clear, parallel load, wrap or saturate mode, and cascade-ready carry/borrow outputs. Used as a building block for address generators, loop indices and timeout timers in datapath controllers. Cascade instances by feeding one stage's co/bo into the next stage's inc/dec.

Parameters:
SIZE, 10, count register width in bits (>= 1).
MODULUS, 1024, number of count states, 0..MODULUS-1; legal range 2 <= MODULUS <= 2**SIZE.
SATURATE, 0, 0 = wrap at the bounds; 1 = hold at the bounds.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
clr  input  1  synchronous clear of the count to 0.
ld  input  1  parallel load enable.
ld_val  input  SIZE  parallel load value.
inc  input  1  count-up enable.
dec  input  1  count-down enable.
count  output  SIZE  current count value (registered).
co  output  1  carry-out, combinational: an up-step is occurring at MODULUS-1.
bo  output  1  borrow-out, combinational: a down-step is occurring at 0.
is_max  output  1  combinational flag: count == MODULUS-1.
is_zero  output  1  combinational flag: count == 0.
wrapped  output  1  registered one-cycle pulse: the previous edge wrapped the count (either direction).

Behaviour:
- Reset is synchronous and active-high. On rst at a clock edge: count=0, wrapped=0.
- Control priority per edge, highest first: rst > clr > ld > step.
  - clr: count<=0, wrapped<=0.
  - ld: count<=ld_val if ld_val<MODULUS; otherwise count<=MODULUS-1 (clamp). wrapped<=0.
- Step is defined as up = inc & ~dec, down = dec & ~inc. If inc and dec are both high, or both low, the count holds and wrapped<=0.
- Up-step:
  - count<MODULUS-1: count+1.
  - count==MODULUS-1 and SATURATE=0: count<=0, wrapped<=1.
  - count==MODULUS-1 and SATURATE=1: hold, wrapped<=0.
- Down-step:
  - count>0: count-1.
  - count==0 and SATURATE=0: count<=MODULUS-1, wrapped<=1.
  - count==0 and SATURATE=1: hold, wrapped<=0.
- co = up & is_max & ~clr & ~ld & ~rst.
- bo = down & is_zero & ~clr & ~ld & ~rst.
- co and bo assert in both SATURATE modes; the next stage decides what to do with them.
- Latency: count reflects an enable one cycle after the edge that samples it. co, bo, is_max and is_zero are same-cycle combinational. wrapped is valid for exactly the cycle after the wrapping edge.
- Arithmetic: modulo compare at SIZE bits. When MODULUS == 2**SIZE, MODULUS-1 is the all-ones value; the implementation must not overflow a SIZE-bit constant (use a SIZE+1-bit compare).
- Mid-operation: clr or rst during a step cancels the step; co, bo and wrapped stay low.
- Holding state: count must not change without rst, clr, ld or a legal step.

Test Plan:
- Reset then 12 edges with inc=1, defaults (SIZE=10, MODULUS=1024) -> count=12; is_zero=1 immediately after reset, 0 after the first step.
- MODULUS=10, SATURATE=0, inc held from count=8 -> 8,9,0,1. co=1 only during the cycle count=9. wrapped=1 only in the cycle count=0.
- MODULUS=10, SATURATE=0, dec from count=1 -> 0,9,8. bo=1 only while count=0 with dec. Same with SATURATE=1 -> holds at 0, bo stays 1 while dec is held, wrapped=0.
- MODULUS=10: ld=1 with ld_val=7 -> count=7. ld_val=15 -> count=9 (clamp). Same edge with ld, inc and dec all high -> load wins, count=ld_val.
- inc=dec=1 at count=5 -> count stays 5, co=bo=0. clr with inc at count=9 (MODULUS=10) -> count=0, co=0, wrapped=0.
- Two instances cascaded (SIZE=4, MODULUS=10; low co -> high inc), 100 inc pulses -> {high,low}=0,0 with a single high-stage co at the 100th step; rst asserted at pulse 57 -> both stages read 0 on the next cycle.
